// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants: FSM state encodings, PC select codes and PC stride.
package fetch_unit_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  // Code 2'b11 is deliberately not listed; it falls through to sequential fetch.
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;

  localparam int unsigned PC_STEP = 4;

  function automatic logic is_redirect(input logic [1:0] sel);
    return (sel == SEL_BRANCH) || (sel == SEL_JUMP);
  endfunction

endpackage

// File: rtl/fetch_unit_instr_mem.sv
// Instruction memory: one synchronous write port for the loader and one
// combinational read port for fetch. Contents are never reset.
module instr_mem
  import fetch_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64,
  localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic                  clock,
  input  logic                  write_en,
  input  logic [IDX_W-1:0]      write_index,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [IDX_W-1:0]      read_index,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clock) begin
    if (write_en) begin
      mem[write_index] <= write_data;
    end
  end

  assign read_data = mem[read_index];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: loader-owned memory, IDLE/LOAD/RUN/HALTED control,
// PC redirect/stall/step handling and registered outputs toward decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = {DATA_WIDTH{1'b1}},
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_loading,
  input  logic                  i_load_valid,
  input  logic [DATA_WIDTH-1:0] i_load_address,
  input  logic [DATA_WIDTH-1:0] i_load_instr,
  input  logic                  i_start,
  input  logic                  i_step_mode,
  input  logic                  i_step,
  input  logic                  i_stall,
  input  logic [1:0]            i_select,
  input  logic [DATA_WIDTH-1:0] i_pc_branch,
  input  logic [DATA_WIDTH-1:0] i_pc_jump,
  output logic [DATA_WIDTH-1:0] o_instruccion,
  output logic [DATA_WIDTH-1:0] o_pc_incr,
  output logic                  o_valid,
  output logic                  o_halted,
  output logic [1:0]            o_state
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] instr;
  logic [DATA_WIDTH-1:0] pc_incr;
  logic                  valid;
  logic                  halted;

  logic [DATA_WIDTH-1:0] fetch_word;
  logic [DATA_WIDTH-1:0] pc_next;
  logic [DATA_WIDTH-1:0] target;
  logic                  advance;
  logic                  redirect;
  logic                  unused_addr_bits;

  // Word index uses only PC[IDX_W+1:2], so fetch addresses wrap modulo 4*MEM_DEPTH.
  instr_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clock      (i_clock),
    .write_en   (i_loading && i_load_valid),
    .write_index(i_load_address[IDX_W+1:2]),
    .write_data (i_load_instr),
    .read_index (pc[IDX_W+1:2]),
    .read_data  (fetch_word)
  );

  assign unused_addr_bits = ^{i_load_address[DATA_WIDTH-1:IDX_W+2], i_load_address[1:0]};

  assign pc_next  = pc + DATA_WIDTH'(PC_STEP);
  assign advance  = !i_step_mode || i_step;
  assign redirect = is_redirect(i_select);
  assign target   = (i_select == SEL_JUMP) ? i_pc_jump : i_pc_branch;

  // Loading pre-empts every state; a redirect wins over a stall inside an advance cycle.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      pc      <= RESET_PC;
      instr   <= NOP_WORD;
      pc_incr <= '0;
      valid   <= 1'b0;
      halted  <= 1'b0;
    end else if (i_loading) begin
      state  <= ST_LOAD;
      valid  <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: state <= ST_IDLE;
        ST_IDLE: begin
          if (i_start) begin
            state <= ST_RUN;
            pc    <= RESET_PC;
            valid <= 1'b0;
          end
        end
        ST_RUN: begin
          if (advance) begin
            if (redirect) begin
              pc    <= target;
              instr <= NOP_WORD;
              valid <= 1'b0;
            end else if (!i_stall) begin
              instr   <= fetch_word;
              pc_incr <= pc_next;
              valid   <= 1'b1;
              if (fetch_word == HALT_WORD) begin
                state <= ST_HALTED;
              end else begin
                pc <= pc_next;
              end
            end
          end
        end
        ST_HALTED: begin
          // The halt word stays valid for exactly one cycle, then the stage reports halted.
          valid  <= 1'b0;
          halted <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_instruccion = instr;
  assign o_pc_incr     = pc_incr;
  assign o_valid       = valid;
  assign o_halted      = halted;
  assign o_state       = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a cycle model predicts every post-edge output
// snapshot into a queue, and an independent monitor pops and compares them.
module tb_fetch_unit;

  localparam int          DW     = 32;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_loading, i_load_valid, i_start, i_step_mode, i_step, i_stall;
  logic [31:0] i_load_address, i_load_instr, i_pc_branch, i_pc_jump;
  logic [1:0]  i_select;
  logic [31:0] o_instruccion, o_pc_incr;
  logic        o_valid, o_halted;
  logic [1:0]  o_state;

  fetch_unit #(
    .DATA_WIDTH(DW),
    .MEM_DEPTH (DEPTH),
    .RESET_PC  (RST_PC),
    .HALT_WORD (HALT),
    .NOP_WORD  (NOP)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_loading     (i_loading),
    .i_load_valid  (i_load_valid),
    .i_load_address(i_load_address),
    .i_load_instr  (i_load_instr),
    .i_start       (i_start),
    .i_step_mode   (i_step_mode),
    .i_step        (i_step),
    .i_stall       (i_stall),
    .i_select      (i_select),
    .i_pc_branch   (i_pc_branch),
    .i_pc_jump     (i_pc_jump),
    .o_instruccion (o_instruccion),
    .o_pc_incr     (o_pc_incr),
    .o_valid       (o_valid),
    .o_halted      (o_halted),
    .o_state       (o_state)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic        loading, load_valid, start, step_mode, step, stall;
    logic [31:0] load_address, load_instr, branch, jump;
    logic [1:0]  select;
  } stim_t;

  typedef struct {
    logic [31:0] instr, incr;
    logic        valid, halted;
    logic [1:0]  state;
  } snap_t;

  snap_t expq[$];
  int    tests    = 0;
  int    failures = 0;

  // Reference model: states as plain integers 0..3 (IDLE, LOAD, RUN, HALTED).
  int          m_state;
  logic [31:0] m_pc, m_instr, m_incr;
  logic        m_valid, m_halted;
  logic [31:0] m_mem [DEPTH];

  function automatic int unsigned wordIndex(input logic [31:0] addr);
    return (addr / 4) % DEPTH;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_state  = 0;
    m_pc     = RST_PC;
    m_instr  = NOP;
    m_incr   = 0;
    m_valid  = 0;
    m_halted = 0;
  endtask

  task automatic modelStep(input stim_t s);
    logic [31:0] w;
    if (s.loading) begin
      if (s.load_valid) m_mem[wordIndex(s.load_address)] = s.load_instr;
      m_state  = 1;
      m_valid  = 0;
      m_halted = 0;
    end else if (m_state == 1) begin
      m_state = 0;
    end else if (m_state == 0) begin
      if (s.start) begin
        m_state = 2;
        m_pc    = RST_PC;
        m_valid = 0;
      end
    end else if (m_state == 2) begin
      if (!s.step_mode || s.step) begin
        if (s.select == 2'd1 || s.select == 2'd2) begin
          m_pc    = (s.select == 2'd1) ? s.branch : s.jump;
          m_instr = NOP;
          m_valid = 0;
        end else if (!s.stall) begin
          w       = m_mem[wordIndex(m_pc)];
          m_instr = w;
          m_incr  = m_pc + 32'd4;
          m_valid = 1;
          if (w == HALT) m_state = 3;
          else           m_pc    = m_pc + 32'd4;
        end
      end
    end else begin
      m_valid  = 0;
      m_halted = 1;
    end
  endtask

  function automatic stim_t quiet();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  // Called at a falling edge: drive, predict the next rising edge, wait one cycle.
  task automatic applyStimulus(input stim_t s);
    snap_t e;
    i_loading      = s.loading;
    i_load_valid   = s.load_valid;
    i_load_address = s.load_address;
    i_load_instr   = s.load_instr;
    i_start        = s.start;
    i_step_mode    = s.step_mode;
    i_step         = s.step;
    i_stall        = s.stall;
    i_select       = s.select;
    i_pc_branch    = s.branch;
    i_pc_jump      = s.jump;
    modelStep(s);
    e.instr  = m_instr;
    e.incr   = m_incr;
    e.valid  = m_valid;
    e.halted = m_halted;
    e.state  = 2'(m_state);
    expq.push_back(e);
    @(negedge i_clock);
  endtask

  task automatic loadWord(input logic [31:0] addr, input logic [31:0] data);
    stim_t s = quiet();
    s.loading = 1; s.load_valid = 1; s.load_address = addr; s.load_instr = data;
    applyStimulus(s);
  endtask

  task automatic enterLoadAndStart();
    stim_t s = quiet();
    s.loading = 1;
    applyStimulus(s);
    applyStimulus(quiet());
    s = quiet(); s.start = 1;
    applyStimulus(s);
  endtask

  task automatic seqCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(quiet());
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_instr"},  o_instruccion, NOP);
    checkOutput({tag, "_incr"},   o_pc_incr, 32'h0);
    checkOutput({tag, "_valid"},  32'(o_valid), 32'h0);
    checkOutput({tag, "_halted"}, 32'(o_halted), 32'h0);
    checkOutput({tag, "_state"},  32'(o_state), 32'h0);
  endtask

  initial begin : monitor
    snap_t e;
    forever begin
      @(posedge i_clock);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput("sb_instr",  o_instruccion, e.instr);
        checkOutput("sb_incr",   o_pc_incr, e.incr);
        checkOutput("sb_valid",  32'(o_valid), 32'(e.valid));
        checkOutput("sb_halted", 32'(o_halted), 32'(e.halted));
        checkOutput("sb_state",  32'(o_state), 32'(e.state));
      end
    end
  end

  initial begin : driver
    stim_t s;
    i_reset = 1'b1;
    i_loading = 0; i_load_valid = 0; i_load_address = 0; i_load_instr = 0;
    i_start = 0; i_step_mode = 0; i_step = 0; i_stall = 0; i_select = 0;
    i_pc_branch = 0; i_pc_jump = 0;
    modelReset();
    #1;
    checkResetValues("por");
    @(negedge i_clock);
    i_reset = 1'b0;

    // Three-instruction program ending in HALT, plus a filler word.
    loadWord(32'h0, 32'h2001_0005);
    loadWord(32'h4, 32'h2002_0007);
    loadWord(32'h8, HALT);
    loadWord(32'hC, 32'h0BAD_CAFE);
    applyStimulus(quiet());
    s = quiet(); s.start = 1;
    applyStimulus(s);
    seqCycles(3);
    checkOutput("halt_word_shown", o_instruccion, HALT);
    checkOutput("halt_incr", o_pc_incr, 32'hC);
    seqCycles(1);
    checkOutput("halted_flag", 32'(o_halted), 32'h1);
    s = quiet(); s.select = 2'd2; s.jump = 32'h4;
    applyStimulus(s);
    applyStimulus(s);
    checkOutput("halted_ignores_jump", o_pc_incr, 32'hC);

    // Branch taken while stalled.
    loadWord(32'h8, 32'h2003_0009);
    applyStimulus(quiet());
    s = quiet(); s.start = 1;
    applyStimulus(s);
    seqCycles(1);
    s = quiet(); s.select = 2'd1; s.branch = 32'h10; s.stall = 1;
    applyStimulus(s);
    checkOutput("branch_nop", o_instruccion, NOP);
    checkOutput("branch_valid", 32'(o_valid), 32'h0);
    seqCycles(1);
    checkOutput("branch_wrap_fetch", o_instruccion, 32'h2001_0005);
    checkOutput("branch_wrap_incr", o_pc_incr, 32'h14);

    // Three-cycle stall at PC=8.
    enterLoadAndStart();
    seqCycles(2);
    s = quiet(); s.stall = 1;
    for (int k = 0; k < 3; k++) applyStimulus(s);
    checkOutput("stall_hold_incr", o_pc_incr, 32'h8);
    seqCycles(1);
    checkOutput("stall_resume", o_instruccion, 32'h2003_0009);

    // Step mode with two pulses five cycles apart.
    enterLoadAndStart();
    for (int k = 0; k < 10; k++) begin
      s = quiet(); s.step_mode = 1; s.step = (k == 0 || k == 5);
      applyStimulus(s);
    end
    checkOutput("step_two_advances", o_pc_incr, 32'h8);

    // Jump to the last word, then wrap to index 0.
    s = quiet(); s.select = 2'd2; s.jump = 32'hC;
    applyStimulus(s);
    seqCycles(1);
    checkOutput("jump_last_word", o_instruccion, 32'h0BAD_CAFE);
    checkOutput("jump_incr", o_pc_incr, 32'h10);
    seqCycles(1);
    checkOutput("wrap_index0", o_instruccion, 32'h2001_0005);

    // Asynchronous reset between edges while running.
    seqCycles(1);
    #2;
    i_reset = 1'b1;
    #1;
    checkResetValues("async");
    modelReset();
    @(negedge i_clock);
    i_reset = 1'b0;
    s = quiet(); s.start = 1;
    applyStimulus(s);
    seqCycles(1);
    checkOutput("mem_kept_after_reset", o_instruccion, 32'h2001_0005);

    // Randomised traffic against the model.
    for (int n = 0; n < 800; n++) begin
      s = quiet();
      if ($urandom_range(0, 29) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
          loadWord($urandom, ($urandom_range(0, 3) == 0) ? HALT : $urandom);
        end
      end else begin
        s.loading      = ($urandom_range(0, 39) == 0);
        s.load_valid   = 1'($urandom_range(0, 1));
        s.load_address = $urandom;
        s.load_instr   = $urandom;
        s.start        = ($urandom_range(0, 2) == 0);
        s.step_mode    = ($urandom_range(0, 3) == 0);
        s.step         = 1'($urandom_range(0, 1));
        s.stall        = ($urandom_range(0, 3) == 0);
        s.select       = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
        s.branch       = $urandom;
        s.jump         = $urandom;
        applyStimulus(s);
      end
    end

    for (int k = 0; k < 10 && expq.size() != 0; k++) @(negedge i_clock);
    checkOutput("scoreboard_drain", 32'(expq.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DATA_WIDTH, 32, instruction and PC width in bits.
REQ-002 Parameter MEM_DEPTH, 64, instruction memory depth in words; power of two, >= 2.
REQ-003 Parameter RESET_PC, 0, byte address fetched first after i_start.
REQ-004 Parameter HALT_WORD, 32'hFFFFFFFF, encoding that stops fetch.
REQ-005 Parameter NOP_WORD, 0, word emitted on flush.
REQ-006 i_clock  in  1  single clock; all state changes on its rising edge.
REQ-007 i_reset  in  1  asynchronous, active-high reset.
REQ-008 i_loading  in  1  loader owns memory while high.
REQ-009 i_load_valid  in  1  write i_load_instr this cycle (only while i_loading).
REQ-010 i_load_address  in  DATA_WIDTH  byte address of loaded word.
REQ-011 i_load_instr  in  DATA_WIDTH  word to store.
REQ-012 i_start  in  1  one-cycle pulse; begins execution from IDLE.
REQ-013 i_step_mode  in  1  1 = advance only on i_step.
REQ-014 i_step  in  1  one-cycle advance pulse in step mode.
REQ-015 i_stall  in  1  hazard stall; hold PC and outputs.
REQ-016 i_select  in  2  00 sequential, 01 branch, 10 jump, 11 treated as 00.
REQ-017 i_pc_branch, i_pc_jump  in  DATA_WIDTH each  redirect targets.
REQ-018 o_instruccion  out  DATA_WIDTH  registered fetched word to decode.
REQ-019 o_pc_incr  out  DATA_WIDTH  registered PC+4 of o_instruccion.
REQ-020 o_valid  out  1  o_instruccion is a real instruction (0 on bubble/flush).
REQ-021 o_halted  out  1  HALT_WORD issued; fetch stopped.
REQ-022 o_state  out  2  IDLE=0, LOAD=1, RUN=2, HALTED=3.

Function
REQ-023 FSM transitions: any state with i_loading=1 -> LOAD; LOAD with i_loading=0 -> IDLE; IDLE with i_start -> RUN; RUN on issuing HALT_WORD -> HALTED; HALTED leaves only via i_loading or reset.
REQ-024 Memory word index = PC[log2(MEM_DEPTH)+1:2]; higher bits ignored, so PC wraps modulo 4*MEM_DEPTH; low two bits ignored.
REQ-025 In LOAD, i_load_valid writes i_load_instr at index of i_load_address on the clock edge; PC and outputs hold, o_valid=0.
REQ-026 IDLE->RUN edge sets PC=RESET_PC, o_valid=0; first instruction appears on outputs one cycle later.
REQ-027 An "advance" cycle is RUN with (i_step_mode=0 or i_step=1); non-advance RUN cycles hold everything.
REQ-028 Priority within an advance cycle: redirect (i_select 01/10) > i_stall > sequential.
REQ-029 Redirect: PC <= selected target, o_instruccion <= NOP_WORD, o_valid <= 0, o_pc_incr holds; applies even if i_stall=1.
REQ-030 Stall without redirect: PC, o_instruccion, o_pc_incr, o_valid hold.
REQ-031 Sequential: o_instruccion <= mem[PC], o_pc_incr <= PC+4 (modulo 2^DATA_WIDTH), o_valid <= 1, PC <= PC+4; latency one cycle.
REQ-032 When mem[PC]==HALT_WORD is issued: it appears on o_instruccion with o_valid=1, PC is not incremented, state -> HALTED, o_halted=1 next cycle.
REQ-033 In HALTED, outputs hold except o_valid <= 0 after the first HALTED cycle; redirects and steps ignored.
REQ-034 Memory reads are combinational from the array; a same-cycle load write to the current index is not visible to fetch (no fetch occurs in LOAD).

Reset
REQ-035 i_reset asynchronously sets state IDLE, PC=RESET_PC, o_instruccion=NOP_WORD, o_pc_incr=0, o_valid=0, o_halted=0.
REQ-036 Reset does not clear memory contents; reset mid-RUN or mid-LOAD aborts immediately, returning to IDLE.

Structure
REQ-037 State encodings and i_select codes live in a shared package with the other pipeline constants.
REQ-038 One sub-module, instr_mem (write port + async read, MEM_DEPTH x DATA_WIDTH); PC, FSM and output registers in fetch_unit.

Verification
REQ-039 Load 0x20010005,0x20020007,0xFFFFFFFF at 0,4,8; start -> cycles 1..3 show those words, o_pc_incr 4,8,C, o_valid=1; o_halted=1 next cycle, PC=8.
REQ-040 RUN at PC=4, i_select=01, i_pc_branch=0x10 with i_stall=1 -> next cycle o_instruccion=NOP_WORD, o_valid=0, PC=0x10.
REQ-041 i_stall high 3 cycles at PC=8 -> outputs and PC unchanged 3 cycles; resumes with mem[2].
REQ-042 i_step_mode=1, two i_step pulses 5 cycles apart -> exactly two advances, PC 0->4->8.
REQ-043 MEM_DEPTH=4, jump to 0xC with no halt -> next fetch wraps to index 0, o_pc_incr=0x10.
REQ-044 Assert i_reset mid-RUN between edges -> outputs reset values immediately, state IDLE; memory contents unchanged on restart.
